// File: rtl/fsm_check_pkg.sv
// Shared types for the FSM result checker: checker state encoding and default data width.
package fsm_check_pkg;

    localparam int DEFAULT_WIDTH = 32;

    // 8-bit encoding so the state lines up with the generated fsmState width
    typedef enum logic [7:0] {
        IDLE  = 8'd0,
        CHECK = 8'd1,
        DONE  = 8'd2,
        ERROR = 8'd3
    } fsm_state_e;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/exp_fifo.sv
// Expected-value FIFO: power-of-two depth, head visible combinationally, pointers wrap modulo DEPTH.
// Push while full and pop while empty are ignored; reset empties it.
module exp_fifo
    import fsm_check_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once the count says they are valid
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/fsm_result_checker.sv
// Compares observed FSM output beats against queued expected values; results registered, latency 1.
// Observed beats are accepted only in CHECK with an expected value queued; FSM_CHECK_STICKY_ERR_EN makes the first mismatch terminal.
module fsm_result_checker
    import fsm_check_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             exp_valid,
    input  logic [WIDTH-1:0] exp_data,
    output logic             exp_ready,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic [7:0]       pass_cnt,
    output logic [7:0]       fail_cnt,
    output logic [WIDTH-1:0] fail_data,
    output logic             done
);

    fsm_state_e       state_q, state_d;
    logic [7:0]       pass_cnt_q, pass_cnt_d;
    logic [7:0]       fail_cnt_q, fail_cnt_d;
    logic [WIDTH-1:0] fail_data_q, fail_data_d;
    logic             done_q, done_d;

    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_head;
    logic             exp_acc;
    logic             in_acc;
    logic             beat_match;

    assign exp_ready  = !fifo_full;
    assign in_ready   = (state_q == CHECK) && !fifo_empty;
    assign exp_acc    = exp_valid && exp_ready;
    assign in_acc     = in_valid && in_ready;
    assign beat_match = (in_data == fifo_head);

    exp_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_exp_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (exp_acc),
        .din   (exp_data),
        .pop   (in_acc),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    always_comb begin
        state_d     = state_q;
        pass_cnt_d  = pass_cnt_q;
        fail_cnt_d  = fail_cnt_q;
        fail_data_d = fail_data_q;

        if (in_acc) begin
            if (beat_match) begin
                pass_cnt_d = sat_inc(pass_cnt_q);
            end else begin
                fail_cnt_d  = sat_inc(fail_cnt_q);
                fail_data_d = in_data;
            end
        end

        case (state_q)
            IDLE: begin
                if (exp_acc) state_d = CHECK;
            end
            CHECK: begin
                if (in_acc) begin
`ifdef FSM_CHECK_STICKY_ERR_EN
                    if (!beat_match)  state_d = ERROR;
                    else if (in_last) state_d = DONE;
`else
                    if (in_last) state_d = DONE;
`endif
                end
            end
            default: state_d = state_q;
        endcase

        done_d = (state_d == DONE) || (state_d == ERROR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pass_cnt_q  <= '0;
            fail_cnt_q  <= '0;
            fail_data_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pass_cnt_q  <= pass_cnt_d;
            fail_cnt_q  <= fail_cnt_d;
            fail_data_q <= fail_data_d;
            done_q      <= done_d;
        end
    end

    assign pass_cnt  = pass_cnt_q;
    assign fail_cnt  = fail_cnt_q;
    assign fail_data = fail_data_q;
    assign done      = done_q;

endmodule

// File: tb/tb_fsm_result_checker.sv
// Directed bench for fsm_result_checker: queue-based reference model checked every cycle plus literal expectations.
module tb_fsm_result_checker;

    localparam int W = 32;
    localparam int D = 4;

`ifdef FSM_CHECK_STICKY_ERR_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         exp_valid = 1'b0;
    logic [W-1:0] exp_data = '0;
    logic         exp_ready;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_last = 1'b0;
    logic         in_ready;
    logic [7:0]   pass_cnt;
    logic [7:0]   fail_cnt;
    logic [W-1:0] fail_data;
    logic         done;

    always #5 clk = ~clk;

    fsm_result_checker #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .exp_valid (exp_valid),
        .exp_data  (exp_data),
        .exp_ready (exp_ready),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .pass_cnt  (pass_cnt),
        .fail_cnt  (fail_cnt),
        .fail_data (fail_data),
        .done      (done)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected values as a queue, results as plain counters.
    // m_phase: 0 waiting for first expected value, 1 checking, 2 finished, 3 errored
    logic [W-1:0] m_q[$];
    int           m_pass = 0;
    int           m_fail = 0;
    logic [W-1:0] m_fail_data = '0;
    int           m_phase = 0;

    always @(posedge clk) begin
        bit           ex_ok;
        bit           in_ok;
        logic [W-1:0] h;
        if (reset) begin
            m_q.delete();
            m_pass      = 0;
            m_fail      = 0;
            m_fail_data = '0;
            m_phase     = 0;
        end else begin
            ex_ok = exp_valid && (m_q.size() < D);
            in_ok = in_valid && (m_phase == 1) && (m_q.size() > 0);
            if (in_ok) begin
                h = m_q.pop_front();
                if (h == in_data) begin
                    if (m_pass < 255) m_pass++;
                end else begin
                    if (m_fail < 255) m_fail++;
                    m_fail_data = in_data;
                end
                if (STICKY && (h != in_data)) m_phase = 3;
                else if (in_last)             m_phase = 2;
            end
            if (ex_ok) begin
                m_q.push_back(exp_data);
                if (m_phase == 0) m_phase = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("exp_ready", 32'(exp_ready), 32'(m_q.size() < D));
            chk("in_ready",  32'(in_ready),  32'((m_phase == 1) && (m_q.size() > 0)));
            chk("pass_cnt",  32'(pass_cnt),  32'(m_pass));
            chk("fail_cnt",  32'(fail_cnt),  32'(m_fail));
            chk("fail_data", fail_data,      m_fail_data);
            chk("done",      32'(done),      32'(m_phase >= 2));
        end
    end

    task automatic step(input bit ev, input logic [W-1:0] ed, input bit iv,
                        input logic [W-1:0] id, input bit il, input bit rs);
        exp_valid = ev;
        exp_data  = ed;
        in_valid  = iv;
        in_data   = id;
        in_last   = il;
        reset     = rs;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic push(input logic [W-1:0] v);
        step(1'b1, v, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic beat(input logic [W-1:0] v, input bit last);
        step(1'b0, '0, 1'b1, v, last, 1'b0);
    endtask

    initial begin
        int np;
        int nq;
        #1;
        // Reset state
        do_reset();
        chk_en = 1'b1;
        chk("rst_exp_ready", 32'(exp_ready), 32'd1);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_pass",      32'(pass_cnt),  32'd0);
        chk("rst_fail",      32'(fail_cnt),  32'd0);
        chk("rst_done",      32'(done),      32'd0);

        // Single matching last beat
        push(32'd15);
        chk("s1_in_ready", 32'(in_ready), 32'd1);
        beat(32'd15, 1'b1);
        chk("s1_pass", 32'(pass_cnt), 32'd1);
        chk("s1_fail", 32'(fail_cnt), 32'd0);
        chk("s1_done", 32'(done),     32'd1);
        // DONE keeps accepting pushes until full but never compares
        for (int i = 0; i < 4; i++) push(32'(50 + i));
        chk("s1_full_in_done", 32'(exp_ready), 32'd0);
        beat(32'd50, 1'b0);
        chk("s1_pass_hold", 32'(pass_cnt), 32'd1);
        chk("s1_in_ready_done", 32'(in_ready), 32'd0);

        // Mismatch
        do_reset();
        push(32'd25);
        push(32'd7);
        beat(32'd15, 1'b0);
        chk("s2_fail", 32'(fail_cnt), 32'd1);
        chk("s2_fail_data", fail_data, 32'h0000000F);
`ifdef FSM_CHECK_STICKY_ERR_EN
        chk("s2_done", 32'(done), 32'd1);
        chk("s2_in_ready", 32'(in_ready), 32'd0);
`else
        chk("s2_done", 32'(done), 32'd0);
        chk("s2_in_ready", 32'(in_ready), 32'd1);
`endif
        beat(32'd9, 1'b0);
`ifdef FSM_CHECK_STICKY_ERR_EN
        chk("s2_fail_stuck", 32'(fail_cnt), 32'd1);
        chk("s2_fail_data2", fail_data, 32'h0000000F);
`else
        chk("s2_fail_cont", 32'(fail_cnt), 32'd2);
        chk("s2_fail_data2", fail_data, 32'h00000009);
`endif

        // Overfill: fifth push refused
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push(32'(100 + i));
            if (i == 3) chk("s3_full_after4", 32'(exp_ready), 32'd0);
        end
        chk("s3_full_after5", 32'(exp_ready), 32'd0);
        for (int i = 0; i < 4; i++) beat(32'(100 + i), i == 3);
        chk("s3_pass", 32'(pass_cnt), 32'd4);
        chk("s3_fail", 32'(fail_cnt), 32'd0);
        chk("s3_exp_ready", 32'(exp_ready), 32'd1);

        // Steady occupancy 3 with simultaneous push/pop, pointers wrapping
        do_reset();
        for (int i = 0; i < 3; i++) push(32'(1000 + i));
        np = 1003;
        nq = 1000;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'(np), 1'b1, 32'(nq), 1'b0, 1'b0);
            np++;
            nq++;
        end
        chk("s4_pass10", 32'(pass_cnt), 32'd10);
        chk("s4_exp_ready", 32'(exp_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            beat(32'(nq), i == 2);
            nq++;
        end
        chk("s4_pass13", 32'(pass_cnt), 32'd13);
        chk("s4_fail", 32'(fail_cnt), 32'd0);
        chk("s4_done", 32'(done), 32'd1);

        // Saturation after 300 matches
        do_reset();
        push(32'd0);
        for (int k = 0; k < 300; k++) step(1'b1, 32'(k + 1), 1'b1, 32'(k), 1'b0, 1'b0);
        chk("s5_pass_sat", 32'(pass_cnt), 32'd255);
        chk("s5_fail", 32'(fail_cnt), 32'd0);

        // Reset during CHECK with two entries queued and handshakes offered
        do_reset();
        push(32'd200);
        push(32'd201);
        beat(32'd200, 1'b0);
        chk("s6_pre_pass", 32'(pass_cnt), 32'd1);
        push(32'd202);
        step(1'b1, 32'd203, 1'b1, 32'd201, 1'b0, 1'b1);
        chk("s6_in_ready",  32'(in_ready),  32'd0);
        chk("s6_exp_ready", 32'(exp_ready), 32'd1);
        chk("s6_pass",      32'(pass_cnt),  32'd0);
        chk("s6_fail",      32'(fail_cnt),  32'd0);
        chk("s6_done",      32'(done),      32'd0);

        // Observed beats with an empty FIFO are not accepted
        push(32'd300);
        beat(32'd300, 1'b0);
        beat(32'd5, 1'b0);
        beat(32'd6, 1'b0);
        chk("s7_pass", 32'(pass_cnt), 32'd1);
        chk("s7_fail", 32'(fail_cnt), 32'd0);
        chk("s7_in_ready", 32'(in_ready), 32'd0);

        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
